// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage that performs loads/stores over a byte-wide request/ack bus
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        me_w_enable,
    input  logic [4:0]  me_w_addr,
    input  logic [31:0] me_w_data,
    input  logic [7:0]  me_aluop,
    input  logic [31:0] me_mem_addr,
    input  logic [5:0]  stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        wb_w_enable,
    output logic [4:0]  wb_w_addr,
    output logic [31:0] wb_w_data,
    output logic        stallreq_me
);

    localparam logic [7:0] EX_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EX_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EX_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EX_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EX_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EX_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EX_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EX_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic        is_mem;
    logic [2:0]  dec_size;
    logic        dec_signed;
    logic        dec_store;

    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic        sign_q;
    logic        store_q;
    logic [31:0] wdata_q;
    logic        en_q;
    logic [4:0]  waddr_q;
    logic [1:0]  cnt;
    logic [31:0] load_buf;
    logic [31:0] load_value;
    logic        last_byte;

    logic        unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

    always_comb begin
        is_mem     = 1'b1;
        dec_size   = 3'd1;
        dec_signed = 1'b0;
        dec_store  = 1'b0;
        case (me_aluop)
            EX_LB_OP:  begin dec_size = 3'd1; dec_signed = 1'b1; end
            EX_LBU_OP: begin dec_size = 3'd1; end
            EX_LH_OP:  begin dec_size = 3'd2; dec_signed = 1'b1; end
            EX_LHU_OP: begin dec_size = 3'd2; end
            EX_LW_OP:  begin dec_size = 3'd4; end
            EX_SB_OP:  begin dec_size = 3'd1; dec_store = 1'b1; end
            EX_SH_OP:  begin dec_size = 3'd2; dec_store = 1'b1; end
            EX_SW_OP:  begin dec_size = 3'd4; dec_store = 1'b1; end
            default:   begin is_mem = 1'b0; end
        endcase
    end

    assign last_byte = ({1'b0, cnt} == (size_q - 3'd1));

    always_comb begin
        case (size_q)
            3'd1:    load_value = {{24{sign_q & load_buf[7]}}, load_buf[7:0]};
            3'd2:    load_value = {{16{sign_q & load_buf[15]}}, load_buf[15:0]};
            default: load_value = load_buf;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = 8'd0;
        wb_w_enable = 1'b0;
        wb_w_addr   = 5'd0;
        wb_w_data   = 32'd0;
        stallreq_me = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    stallreq_me = 1'b1;
                    state_d     = XFER;
                end else begin
                    wb_w_enable = me_w_enable;
                    wb_w_addr   = me_w_addr;
                    wb_w_data   = me_w_data;
                end
            end
            XFER: begin
                mem_req     = 1'b1;
                mem_we      = store_q;
                mem_addr    = addr_q + {30'd0, cnt};
                mem_wdata   = wdata_q[{cnt, 3'b000} +: 8];
                stallreq_me = 1'b1;
                if (mem_ack && last_byte) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!store_q) begin
                    wb_w_enable = en_q;
                    wb_w_addr   = waddr_q;
                    wb_w_data   = load_value;
                end
                // Result stays on wb_* until MEM/WB is allowed to take it.
                if (!stall[4]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 2'd0;
            load_buf <= 32'd0;
            addr_q   <= 32'd0;
            size_q   <= 3'd1;
            sign_q   <= 1'b0;
            store_q  <= 1'b0;
            wdata_q  <= 32'd0;
            en_q     <= 1'b0;
            waddr_q  <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_mem) begin
                        addr_q  <= me_mem_addr;
                        size_q  <= dec_size;
                        sign_q  <= dec_signed;
                        store_q <= dec_store;
                        wdata_q <= me_w_data;
                        en_q    <= me_w_enable;
                        waddr_q <= me_w_addr;
                        cnt     <= 2'd0;
                    end
                end
                XFER: begin
                    if (mem_ack) begin
                        if (!store_q) begin
                            load_buf[{cnt, 3'b000} +: 8] <= mem_rdata;
                        end
                        if (!last_byte) begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
